// File: rtl/seg7_mux_counter_pkg.sv
// Purpose: shared constants and helpers for the seg7_mux_counter slice:
//   BCD digit width, 7-segment patterns ({dp,g,f,e,d,c,b,a}, active-high),
//   the BCD-to-segment encoder and the per-digit load clamp.
// Ports: none (package).
package seg7_mux_counter_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 8;

  localparam logic [SEG_W-1:0] SEG_0     = 8'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 8'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 8'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 8'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 8'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 8'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  // BCD digit to segment pattern; non-BCD codes show nothing
  function automatic logic [SEG_W-1:0] seg7_encode(input logic [BCD_W-1:0] bcd);
    logic [SEG_W-1:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Saturate a nibble to a legal BCD digit
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

endpackage

// File: rtl/seg7_mux_counter_if.sv
// Purpose: control/status bundle of seg7_mux_counter.
//   master (controller side) drives en, up_dn, clr, load, load_val and
//   observes count_bcd, wrap, seg, an; slave is the counter itself.
interface seg7_mux_counter_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned CNT_W = seg7_mux_counter_pkg::BCD_W * NUM_DIGITS;
  localparam int unsigned SEG_W = seg7_mux_counter_pkg::SEG_W;

  logic                  en;
  logic                  up_dn;
  logic                  clr;
  logic                  load;
  logic [CNT_W-1:0]      load_val;
  logic [CNT_W-1:0]      count_bcd;
  logic                  wrap;
  logic [SEG_W-1:0]      seg;
  logic [NUM_DIGITS-1:0] an;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  count_bcd, wrap, seg, an
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output count_bcd, wrap, seg, an
  );
endinterface

// File: rtl/seg7_mux_counter_bcd_digit.sv
// Purpose: one BCD up/down digit with synchronous clear and clamped load.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_clr, i_load   synchronous clear / load (clear wins)
//   i_load_val      nibble to load, clamped to 9
//   i_up            1 = increment, 0 = decrement
//   i_cin           step request from the digit below (or the tick)
//   o_digit         current digit value (register)
//   o_cout_c        step request for the digit above (combinational)
module seg7_mux_counter_bcd_digit
  import seg7_mux_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_val,
  input  logic             i_up,
  input  logic             i_cin,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_cout_c
);

  logic [BCD_W-1:0] r_digit;
  logic             w_at_limit;

  // 9 when counting up, 0 when counting down: this step wraps the digit
  assign w_at_limit = i_up ? (r_digit == 4'd9) : (r_digit == 4'd0);
  assign o_cout_c   = i_cin & w_at_limit;
  assign o_digit    = r_digit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digit <= '0;
    end else if (i_clr) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= bcd_clamp(i_load_val);
    end else if (i_cin) begin
      if (i_up) r_digit <= w_at_limit ? 4'd0 : r_digit + 4'd1;
      else      r_digit <= w_at_limit ? 4'd9 : r_digit - 4'd1;
    end
  end

endmodule

// File: rtl/seg7_mux_counter.sv
// Purpose: N-digit BCD up/down counter driving a time-multiplexed 7-segment
//   display, with prescaler, scan divider, leading-zero blanking and a
//   wrap pulse on roll-over / roll-under.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   slave side of seg7_mux_counter_if (en, up_dn, clr, load, load_val
//         in; count_bcd, wrap, seg, an out)
module seg7_mux_counter
  import seg7_mux_counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned CLK_DIV        = 1,
  parameter int unsigned SCAN_DIV       = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          BLANK_LZ       = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  seg7_mux_counter_if.slave   bus
);

  localparam int unsigned CNT_W = BCD_W * NUM_DIGITS;
  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
  localparam logic [SCN_W-1:0] SCN_MAX = SCN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]      r_presc;
  logic                  w_tick;
  logic [NUM_DIGITS:0]   w_carry;
  logic [CNT_W-1:0]      w_count;
  logic                  r_wrap;
  logic [SCN_W-1:0]      r_scan_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_DIGITS-1:0] w_zero_from;
  logic [BCD_W-1:0]      w_sel_digit;
  logic                  w_sel_blank;
  logic [SEG_W-1:0]      w_seg_next;
  logic [SEG_W-1:0]      r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  // Count-tick prescaler; frozen while paused, restarted by clr/load
  assign w_tick = bus.en && (r_presc == PRE_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_presc <= '0;
    else if (bus.clr || bus.load)  r_presc <= '0;
    else if (bus.en)               r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
  end

  // Digit chain: the tick enters digit 0 and ripples while digits sit at their limit
  assign w_carry[0] = w_tick;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    seg7_mux_counter_bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (bus.clr),
      .i_load     (bus.load),
      .i_load_val (bus.load_val[k*BCD_W +: BCD_W]),
      .i_up       (bus.up_dn),
      .i_cin      (w_carry[k]),
      .o_digit    (w_count[k*BCD_W +: BCD_W]),
      .o_cout_c   (w_carry[k+1])
    );
    // Digit k and everything above it are zero
    assign w_zero_from[k] = ~|w_count[CNT_W-1:k*BCD_W];
  end

  // Carry out of the top digit is the wrap, unless clr/load overrides the step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wrap <= 1'b0;
    else      r_wrap <= w_carry[NUM_DIGITS] && !bus.clr && !bus.load;
  end

  // Digit scan, free-running regardless of en/clr/load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == SCN_MAX) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SCN_W'(1);
    end
  end

  // Segment pattern for the currently selected digit
  assign w_sel_digit = w_count[BCD_W*int'(r_idx) +: BCD_W];
  assign w_sel_blank = BLANK_LZ && (r_idx != '0) && w_zero_from[r_idx];
  assign w_seg_next  = w_sel_blank ? SEG_BLANK : seg7_encode(w_sel_digit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg <= SEG_0;
      r_an  <= NUM_DIGITS'(1);
    end else begin
      r_seg <= w_seg_next;
      r_an  <= NUM_DIGITS'(1) << r_idx;
    end
  end

  // Pin polarity; dp bit stays at its inactive level
  assign bus.seg       = r_seg ^ {SEG_W{SEG_ACTIVE_LOW}};
  assign bus.an        = r_an ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};
  assign bus.count_bcd = w_count;
  assign bus.wrap      = r_wrap;

endmodule
